alu_mc: RTL and testbench

Parametrised multi-cycle ALU for the MIPS datapath execute stage. It generalises the single-cycle execute ALU with a configurable data width and an iterative shift-add multiplier and restoring divider. It uses a valid/ready handshake on both sides, so the control unit can stall on long operations instead of relying on a fixed stage number. One operation is in flight at a time; result, ZERO and error flags are registered and held until consumed.

---
 rtl/alu_mc.sv | 118 +++++++++++
 tb/tb_alu_mc.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/alu_mc.sv
// alu_mc: multi-cycle MIPS execute ALU with shift-add multiply and restoring divide,
// valid/ready on both sides; one operation in flight, results held until consumed.
module alu_mc #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] read_data1,
    input  logic [WIDTH-1:0] read_data2,
    input  logic [WIDTH-1:0] sign_extend,
    input  logic             ALU_Src,
    input  logic [1:0]       alu_op,
    input  logic [5:0]       alu_funct,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             ZERO,
    output logic             div_by_zero,
    output logic             illegal_op
);
    localparam int CW = $clog2(WIDTH) + 1;
    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;
    typedef enum logic [2:0] {OP_AND, OP_OR, OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_ILL} op_t;
    state_t state, state_nxt;
    op_t op;
    logic [WIDTH-1:0] b_in, quick, a_reg, b_reg, acc, rem_diff;
    logic [WIDTH:0] rem_sh;
    logic rem_ge, accept;
    logic [CW-1:0] cnt;
    assign b_in = ALU_Src ? sign_extend : read_data2;
    assign in_ready = state == IDLE;
    assign out_valid = state == DONE;
    assign accept = in_valid && in_ready;
    // restoring divide step: a_reg shifts the dividend out MSB-first while the quotient shifts in
    assign rem_sh = {acc, a_reg[WIDTH-1]};
    assign rem_ge = rem_sh >= {1'b0, b_reg};
    assign rem_diff = rem_sh[WIDTH-1:0] - b_reg;
    always_comb begin
        op = OP_ILL;
        if (alu_op == 2'b11) op = OP_ADD;
        else if (alu_op == 2'b01) op = OP_SUB;
        else if (alu_op == 2'b00)
            case (alu_funct)
                6'b100100: op = OP_AND;
                6'b100101: op = OP_OR;
                6'b100000: op = OP_ADD;
                6'b100010: op = OP_SUB;
                6'b011000: op = OP_MUL;
                6'b011010: op = OP_DIV;
                default:   op = OP_ILL;
            endcase
    end
    always_comb begin
        quick = op == OP_AND ? read_data1 & b_in :
                op == OP_OR  ? read_data1 | b_in :
                op == OP_ADD ? read_data1 + b_in :
                op == OP_SUB ? read_data1 - b_in : '0;
    end
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (accept) state_nxt = op == OP_MUL ? MUL : op == OP_DIV ? DIV : DONE;
            MUL, DIV: if (cnt == '0) state_nxt = DONE;
            DONE:     if (out_ready) state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end
    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else state <= state_nxt;
    end
    always_ff @(posedge clock) begin
        if (reset) begin
            a_reg <= '0;
            b_reg <= '0;
            acc <= '0;
            cnt <= '0;
            result <= '0;
            ZERO <= 1'b0;
            div_by_zero <= 1'b0;
            illegal_op <= 1'b0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    a_reg <= read_data1;
                    b_reg <= b_in;
                    acc <= '0;
                    cnt <= CW'(WIDTH);
                    result <= quick;
                    ZERO <= quick == '0;
                    div_by_zero <= 1'b0;
                    illegal_op <= op == OP_ILL;
                end
                MUL: if (cnt != '0) begin
                    acc <= acc + (b_reg[0] ? a_reg : '0);
                    a_reg <= a_reg << 1;
                    b_reg <= b_reg >> 1;
                    cnt <= cnt - CW'(1);
                end else begin
                    result <= acc;
                    ZERO <= acc == '0;
                end
                DIV: if (cnt != '0) begin
                    acc <= rem_ge ? rem_diff : rem_sh[WIDTH-1:0];
                    a_reg <= {a_reg[WIDTH-2:0], rem_ge};
                    cnt <= cnt - CW'(1);
                end else begin
                    result <= a_reg;
                    ZERO <= a_reg == '0;
                    div_by_zero <= b_reg == '0;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_mc.sv
// tb_alu_mc: directed scoreboard bench for alu_mc at WIDTH=32, plus a WIDTH=8 multiply check.
module tb_alu_mc;
    typedef struct {
        logic [31:0] res;
        logic z, dz, il;
        int lat;
    } exp_t;
    exp_t sb[$];
    int total = 0, bad = 0;
    logic clock = 0, reset = 1;
    logic in_valid = 0, in_ready, ALU_Src = 0, out_valid, out_ready = 1;
    logic ZERO, div_by_zero, illegal_op;
    logic [31:0] read_data1 = 0, read_data2 = 0, sign_extend = 0, result;
    logic [1:0] alu_op = 0;
    logic [5:0] alu_funct = 0;
    logic in_valid8 = 0, in_ready8, out_valid8, zero8, dbz8, ill8;
    logic [7:0] a8 = 0, b8 = 0, result8;
    always #5 clock = ~clock;
    alu_mc #(.WIDTH(32)) u_alu (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .read_data1(read_data1), .read_data2(read_data2), .sign_extend(sign_extend),
        .ALU_Src(ALU_Src), .alu_op(alu_op), .alu_funct(alu_funct), .out_valid(out_valid),
        .out_ready(out_ready), .result(result), .ZERO(ZERO), .div_by_zero(div_by_zero),
        .illegal_op(illegal_op)
    );
    alu_mc #(.WIDTH(8)) u_alu8 (
        .clock(clock), .reset(reset), .in_valid(in_valid8), .in_ready(in_ready8),
        .read_data1(a8), .read_data2(b8), .sign_extend(8'h00), .ALU_Src(1'b0),
        .alu_op(2'b00), .alu_funct(6'b011000), .out_valid(out_valid8), .out_ready(1'b1),
        .result(result8), .ZERO(zero8), .div_by_zero(dbz8), .illegal_op(ill8)
    );
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask
    task automatic drive(input logic [31:0] a, input logic [31:0] rd2, input logic [31:0] se,
                         input logic src, input logic [1:0] op, input logic [5:0] fn,
                         input logic [31:0] er, input logic ez, input logic edz,
                         input logic eil, input int elat);
        exp_t e;
        @(negedge clock);
        read_data1 = a;
        read_data2 = rd2;
        sign_extend = se;
        ALU_Src = src;
        alu_op = op;
        alu_funct = fn;
        in_valid = 1;
        chk("in_ready_at_issue", 64'(in_ready), 64'(1));
        e.res = er;
        e.z = ez;
        e.dz = edz;
        e.il = eil;
        e.lat = elat;
        sb.push_back(e);
        @(posedge clock);
        @(negedge clock);
        in_valid = 0;
        // operands must already be captured, so scramble the inputs
        read_data1 = '1;
        read_data2 = '1;
        sign_extend = '1;
        alu_op = 2'b10;
    endtask
    task automatic collect(input string tag);
        exp_t e;
        int k = 0;
        while (!out_valid && k < 200) begin
            @(negedge clock);
            k++;
        end
        chk({tag, "_sb_nonempty"}, 64'(sb.size() != 0), 64'(1));
        if (sb.size() == 0) return;
        e = sb.pop_front();
        chk({tag, "_latency"}, 64'(k), 64'(e.lat));
        chk({tag, "_out_valid"}, 64'(out_valid), 64'(1));
        chk({tag, "_result"}, 64'(result), 64'(e.res));
        chk({tag, "_zero"}, 64'(ZERO), 64'(e.z));
        chk({tag, "_div_by_zero"}, 64'(div_by_zero), 64'(e.dz));
        chk({tag, "_illegal_op"}, 64'(illegal_op), 64'(e.il));
        out_ready = 1;
        @(posedge clock);
        @(negedge clock);
        chk({tag, "_in_ready_after"}, 64'(in_ready), 64'(1));
        chk({tag, "_out_valid_after"}, 64'(out_valid), 64'(0));
    endtask
    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end
    initial begin
        exp_t d;
        int k;
        repeat (3) @(posedge clock);
        @(negedge clock);
        reset = 0;
        chk("rst_in_ready", 64'(in_ready), 64'(1));
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_result", 64'(result), 64'(0));
        chk("rst_flags", 64'({ZERO, div_by_zero, illegal_op}), 64'(0));
        chk("rst8_in_ready", 64'(in_ready8), 64'(1));
        drive(30, 0, 64, 1, 2'b11, 6'd0, 94, 0, 0, 0, 0);
        collect("addi");
        drive(30, 25, 0, 0, 2'b00, 6'b011000, 750, 0, 0, 0, 33);
        collect("mul_30x25");
        drive(32'hFFFF_FFFF, 2, 0, 0, 2'b00, 6'b011000, 32'hFFFF_FFFE, 0, 0, 0, 33);
        collect("mul_ovf");
        drive(100, 7, 0, 0, 2'b00, 6'b011010, 14, 0, 0, 0, 33);
        collect("div_100_7");
        drive(5, 0, 0, 0, 2'b00, 6'b011010, 32'hFFFF_FFFF, 0, 1, 0, 33);
        collect("div_by_0");
        drive(25, 0, 25, 1, 2'b01, 6'd0, 0, 1, 0, 0, 0);
        collect("sub_eq");
        drive(32'hF0F0, 32'h0FF0, 0, 0, 2'b00, 6'b100100, 32'h00F0, 0, 0, 0, 0);
        collect("and");
        drive(32'hF0F0, 32'h0FF0, 0, 0, 2'b00, 6'b100101, 32'hFFF0, 0, 0, 0, 0);
        collect("or");
        drive(32'hFFFF_FFFF, 1, 0, 0, 2'b00, 6'b100000, 0, 1, 0, 0, 0);
        collect("add_wrap");
        out_ready = 0;
        drive(50, 8, 0, 0, 2'b00, 6'b100010, 42, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            in_valid = (i % 2) == 0;
            read_data1 = 3;
            read_data2 = 4;
            alu_op = 2'b11;
            @(negedge clock);
            chk("bp_out_valid", 64'(out_valid), 64'(1));
            chk("bp_result", 64'(result), 64'(42));
            chk("bp_in_ready", 64'(in_ready), 64'(0));
        end
        in_valid = 0;
        collect("bp_sub");
        drive(1000, 3, 0, 0, 2'b00, 6'b011010, 333, 0, 0, 0, 33);
        repeat (9) @(negedge clock);
        reset = 1;
        @(posedge clock);
        @(negedge clock);
        reset = 0;
        d = sb.pop_front();
        chk("abort_in_ready", 64'(in_ready), 64'(1));
        chk("abort_out_valid", 64'(out_valid), 64'(0));
        chk("abort_result", 64'(result), 64'(0));
        repeat (40) @(negedge clock);
        chk("abort_no_output", 64'(out_valid), 64'(0));
        drive(7, 9, 0, 0, 2'b00, 6'b101010, 0, 1, 0, 1, 0);
        collect("illegal_funct");
        drive(7, 9, 0, 0, 2'b10, 6'b100000, 0, 1, 0, 1, 0);
        collect("illegal_aluop");
        @(negedge clock);
        a8 = 15;
        b8 = 17;
        in_valid8 = 1;
        d.res = 255;
        d.z = 0;
        d.dz = 0;
        d.il = 0;
        d.lat = 9;
        sb.push_back(d);
        @(posedge clock);
        @(negedge clock);
        in_valid8 = 0;
        a8 = 0;
        k = 0;
        while (!out_valid8 && k < 100) begin
            @(negedge clock);
            k++;
        end
        d = sb.pop_front();
        chk("w8_latency", 64'(k), 64'(d.lat));
        chk("w8_result", 64'(result8), 64'(d.res));
        chk("w8_flags", 64'({zero8, dbz8, ill8}), 64'({d.z, d.dz, d.il}));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
